alu_serial_addsub: RTL and testbench

//  Parametrised multi-cycle ALU for the Execute stage: add/sub/and/xor on WIDTH-bit
//  two's-complement operands, processing CHUNK bits per cycle with a rippled carry.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/addsub_chunk.sv | 30 +++
 rtl/alu_serial_addsub.sv | 150 +++++++++++++++
 tb/tb_alu_serial_addsub.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the serial add/sub/logic ALU.
// Op codes, condition-code bit positions and FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

    localparam int CC_ZF = 0;
    localparam int CC_SF = 1;
    localparam int CC_OF = 2;

    localparam logic [2:0] CC_RESET = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } alu_state_e;

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-bit slice of the serial ALU.
// Combinational; the FSM reuses it every RUN cycle.
module addsub_chunk
    import alu_pkg::*;
#(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    input  alu_op_e          op,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    always_comb begin
        sum  = '0;
        cout = 1'b0;
        unique case (op)
            ALU_ADD, ALU_SUB: begin
                {cout, sum} = {1'b0, a} + {1'b0, b}
                            + {{CHUNK{1'b0}}, cin};
            end
            ALU_AND: sum = a & b;
            ALU_XOR: sum = a ^ b;
            default: sum = '0;
        endcase
    end

endmodule

// File: rtl/alu_serial_addsub.sv
// Multi-cycle Execute ALU: CHUNK bits per cycle, rippled carry,
// valid/ready on both sides, owns the architectural CC register.
module alu_serial_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags,
    output logic [2:0]       cc
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = $clog2(NCHUNK) + 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("WIDTH must be a multiple of CHUNK");
    end

    alu_state_e       state;
    alu_state_e       state_nxt;
    alu_op_e          op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             set_cc_q;
    logic             a_msb;
    logic             b_msb;
    logic             carry_q;
    logic             zf_acc;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic [CHUNK-1:0] sum;
    logic             cout;
    logic             zf_nxt;
    logic             of_nxt;
    logic [WIDTH-1:0] sum_top;

    assign last    = (cnt == CNT_W'(NCHUNK - 1));
    assign zf_nxt  = zf_acc & ~|sum;
    assign sum_top = WIDTH'(sum) << (WIDTH - CHUNK);

    // Overflow uses the operand sign bits captured before b was inverted.
    always_comb begin
        of_nxt = 1'b0;
        unique case (1'b1)
            (op_q == ALU_ADD):
                of_nxt = (a_msb == b_msb) && (sum[CHUNK-1] != a_msb);
            (op_q == ALU_SUB):
                of_nxt = (a_msb != b_msb) && (sum[CHUNK-1] != a_msb);
            default: of_nxt = 1'b0;
        endcase
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_q[CHUNK-1:0]),
        .b    (b_q[CHUNK-1:0]),
        .cin  (carry_q),
        .op   (op_q),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (1'b1)
            (state == IDLE): in_ready  = 1'b1;
            (state == DONE): out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= ALU_ADD;
            a_q      <= '0;
            b_q      <= '0;
            set_cc_q <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            carry_q  <= 1'b0;
            zf_acc   <= 1'b1;
            cnt      <= '0;
            result   <= '0;
            flags    <= '0;
            cc       <= CC_RESET;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= alu_op_e'(op);
                        a_q      <= a;
                        b_q      <= (alu_op_e'(op) == ALU_SUB) ? ~b : b;
                        set_cc_q <= set_cc;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
                        carry_q  <= (alu_op_e'(op) == ALU_SUB);
                        zf_acc   <= 1'b1;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    // Operands shift down; result fills from the top.
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    result  <= (result >> CHUNK) | sum_top;
                    carry_q <= cout;
                    zf_acc  <= zf_nxt;
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        flags[CC_ZF] <= zf_nxt;
                        flags[CC_SF] <= sum[CHUNK-1];
                        flags[CC_OF] <= of_nxt;
                    end
                end
                DONE: begin
                    if (out_ready && set_cc_q) cc <= flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_addsub.sv
// Directed + random bench for alu_serial_addsub with a result scoreboard.
// Extra instances cover CHUNK=8 and CHUNK=64 latency.
module tb_alu_serial_addsub;

    typedef struct {
        logic [63:0] r;
        logic [2:0]  f;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op_i;
    logic [63:0] a_i;
    logic [63:0] b_i;
    logic        set_cc_i;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [2:0]  flags;
    logic [2:0]  cc;

    logic        iv_x  [2];
    logic        ir_x  [2];
    logic        ov_x  [2];
    logic [63:0] res_x [2];
    logic [2:0]  flg_x [2];
    logic [2:0]  cc_x  [2];

    exp_t        sb[$];
    int          n_chk;
    int          n_fail;
    logic [2:0]  cc_model;

    alu_serial_addsub #(.WIDTH(64), .CHUNK(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_i),
        .a         (a_i),
        .b         (b_i),
        .set_cc    (set_cc_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .cc        (cc)
    );

    for (genvar g = 0; g < 2; g++) begin : g_var
        alu_serial_addsub #(.WIDTH(64), .CHUNK(g == 0 ? 8 : 64)) dut_x (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv_x[g]),
            .in_ready  (ir_x[g]),
            .op        (op_i),
            .a         (a_i),
            .b         (b_i),
            .set_cc    (set_cc_i),
            .out_valid (ov_x[g]),
            .out_ready (out_ready),
            .result    (res_x[g]),
            .flags     (flg_x[g]),
            .cc        (cc_x[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o,
                                   input logic [63:0] x, y);
        logic [64:0] s;
        logic        of;
        exp_t        e;
        s  = '0;
        of = 1'b0;
        case (o)
            2'b00: s = {x[63], x} + {y[63], y};
            2'b01: s = {x[63], x} - {y[63], y};
            2'b10: s = {1'b0, x & y};
            default: s = {1'b0, x ^ y};
        endcase
        if (o[1] == 1'b0) of = s[64] ^ s[63];
        e.r = s[63:0];
        e.f = {of, s[63], (s[63:0] == 64'd0)};
        return e;
    endfunction

    task automatic do_op(input string tag, input logic [1:0] o,
                         input logic [63:0] x, y, input logic sc,
                         input logic [63:0] er, input logic [2:0] ef,
                         input int hold);
        int   n;
        exp_t e;
        logic [63:0] r0;
        logic [2:0]  f0;
        op_i      = o;
        a_i       = x;
        b_i       = y;
        set_cc_i  = sc;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        op_i     = ~o;
        a_i      = ~x;
        b_i      = ~y;
        set_cc_i = ~sc;
        sb.push_back('{er, ef});
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd4);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_result"}, result, e.r);
            chk({tag, "_flags"}, 64'(flags), 64'(e.f));
        end
        r0 = result;
        f0 = flags;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op_i     = 2'(i);
            a_i      = 64'(i + 7);
            step();
            chk({tag, "_hold_res"}, result, r0);
            chk({tag, "_hold_flg"}, 64'(flags), 64'(f0));
            chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
            chk({tag, "_hold_ov"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_cc"}, 64'(cc), 64'(cc_model));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        if (sc) cc_model = ef;
        chk({tag, "_cc"}, 64'(cc), 64'(cc_model));
        chk({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
        chk({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic lat_x(input int g, input int lat);
        int   n;
        exp_t e;
        op_i     = 2'b00;
        a_i      = 64'h7FFF_FFFF_FFFF_FFFF;
        b_i      = 64'd1;
        set_cc_i = 1'b1;
        iv_x[g]  = 1'b1;
        step();
        iv_x[g]  = 1'b0;
        a_i      = 64'd0;
        sb.push_back('{64'h8000_0000_0000_0000, 3'b110});
        n = 0;
        while (!ov_x[g] && n < 20) begin
            step();
            n++;
        end
        chk($sformatf("lat_x%0d", g), 64'(n), 64'(lat));
        e = sb.pop_front();
        chk($sformatf("res_x%0d", g), res_x[g], e.r);
        chk($sformatf("flg_x%0d", g), 64'(flg_x[g]), 64'(e.f));
        step();
        chk($sformatf("cc_x%0d", g), 64'(cc_x[g]), 64'h6);
        chk($sformatf("ov_x%0d", g), 64'(ov_x[g]), 64'd0);
    endtask

    initial begin
        exp_t e;
        logic [1:0]  ro;
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rs;
        bit          pulsed;
        n_chk     = 0;
        n_fail    = 0;
        cc_model  = 3'b001;
        rst       = 1'b1;
        in_valid  = 1'b0;
        iv_x[0]   = 1'b0;
        iv_x[1]   = 1'b0;
        op_i      = 2'b00;
        a_i       = '0;
        b_i       = '0;
        set_cc_i  = 1'b0;
        out_ready = 1'b1;

        step();
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_cc", 64'(cc), 64'h1);
        chk("rst_result", result, 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        rst = 1'b0;
        step();
        step();
        step();
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        do_op("sub_eq", 2'b01, 64'd5, 64'd5, 1'b1, 64'd0, 3'b001, 0);
        do_op("add_of", 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1,
              64'h8000_0000_0000_0000, 3'b110, 0);
        do_op("sub_of", 2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b1,
              64'h7FFF_FFFF_FFFF_FFFF, 3'b100, 0);
        do_op("carry", 2'b00, 64'h0000_0000_0000_FFFF, 64'd1, 1'b1,
              64'h0000_0000_0001_0000, 3'b000, 0);
        do_op("xor_z", 2'b11, 64'hDEAD_BEEF_0000_0001,
              64'hDEAD_BEEF_0000_0001, 1'b0, 64'd0, 3'b001, 0);
        do_op("and_bp", 2'b10, 64'hF0F0_F0F0_F0F0_F0F0,
              64'hFF00_FF00_FF00_FF00, 1'b1,
              64'hF000_F000_F000_F000, 3'b010, 5);

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = {$urandom(), $urandom()};
            rb = (i == 3) ? ra : {$urandom(), $urandom()};
            rs = 1'($urandom_range(0, 1));
            e  = model(ro, ra, rb);
            do_op($sformatf("rnd%0d", i), ro, ra, rb, rs, e.r, e.f, 0);
        end

        op_i     = 2'b01;
        a_i      = 64'h8000_0000_0000_0000;
        b_i      = 64'd1;
        set_cc_i = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cc_model = 3'b001;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_cc", 64'(cc), 64'(cc_model));
        chk("abort_result", result, 64'd0);
        pulsed = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) pulsed = 1'b1;
        end
        chk("abort_no_pulse", 64'(pulsed), 64'd0);

        lat_x(0, 8);
        lat_x(1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
